// File: rtl/iob_tdp_ram_be_arb.sv
// iob_tdp_ram_be_arb
// Round-robin arbiter/sequencer in front of one port of a byte-enable
// true dual-port RAM. After reset (or on clr) every word is zeroed, then
// two valid/ready requesters share the port, one access per cycle.
// Read data comes straight from the RAM's registered output and is
// qualified by a per-requester rvalid strobe one cycle after acceptance.

module iob_tdp_ram_be_arb #(
  parameter int NUM_COL   = 2,
  parameter int COL_WIDTH = 4,
  parameter int DATA_W    = NUM_COL * COL_WIDTH,
  parameter int ADDR_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  output logic                busy,

  input  logic                r0_valid,
  input  logic [ADDR_W-1:0]   r0_addr,
  input  logic [NUM_COL-1:0]  r0_wstrb,
  input  logic [DATA_W-1:0]   r0_wdata,
  output logic                r0_ready,
  output logic                r0_rvalid,
  output logic [DATA_W-1:0]   r0_rdata,

  input  logic                r1_valid,
  input  logic [ADDR_W-1:0]   r1_addr,
  input  logic [NUM_COL-1:0]  r1_wstrb,
  input  logic [DATA_W-1:0]   r1_wdata,
  output logic                r1_ready,
  output logic                r1_rvalid,
  output logic [DATA_W-1:0]   r1_rdata,

  output logic                ram_en,
  output logic [NUM_COL-1:0]  ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_din,
  input  logic [DATA_W-1:0]   ram_dout
);

  typedef enum logic [1:0] {
    START = 2'd0,
    CLEAR = 2'd1,
    SERVE = 2'd2
  } stateT;

  localparam logic [ADDR_W-1:0]  LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0]  ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0]  ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [NUM_COL-1:0] WE_NONE   = {NUM_COL{1'b0}};
  localparam logic [NUM_COL-1:0] WE_ALL    = {NUM_COL{1'b1}};
  localparam logic [DATA_W-1:0]  DATA_ZERO = {DATA_W{1'b0}};

  stateT             state;
  stateT             stateNext;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cntNext;
  logic              prio;
  logic              prioNext;
  logic              rvalid0;
  logic              rvalid0Next;
  logic              rvalid1;
  logic              rvalid1Next;
  logic              grant0;
  logic              grant1;

  // State, clear counter, round-robin pointer and read-strobe registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= START;
      cnt     <= ADDR_ZERO;
      prio    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      state   <= stateNext;
      cnt     <= cntNext;
      prio    <= prioNext;
      rvalid0 <= rvalid0Next;
      rvalid1 <= rvalid1Next;
    end
  end

  // Next-state, same-cycle grant and RAM port drive.
  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    prioNext    = prio;
    rvalid0Next = 1'b0;
    rvalid1Next = 1'b0;
    grant0      = 1'b0;
    grant1      = 1'b0;
    busy        = 1'b1;
    ram_en      = 1'b0;
    ram_we      = WE_NONE;
    ram_addr    = ADDR_ZERO;
    ram_din     = DATA_ZERO;

    case (state)
      START: begin
        stateNext = CLEAR;
        cntNext   = ADDR_ZERO;
      end

      CLEAR: begin
        ram_en   = 1'b1;
        ram_we   = WE_ALL;
        ram_addr = cnt;
        ram_din  = DATA_ZERO;
        cntNext  = cnt + ADDR_ONE;
        if (cnt == LAST_ADDR) begin
          stateNext = SERVE;
        end else begin
          stateNext = CLEAR;
        end
      end

      SERVE: begin
        busy = 1'b0;
        if (clr) begin
          // A clear request wins over both requesters this cycle.
          stateNext = CLEAR;
          cntNext   = ADDR_ZERO;
        end else begin
          // With both valid, prio picks; otherwise the lone requester wins.
          grant0 = r0_valid & (~r1_valid | ~prio);
          grant1 = r1_valid & (~r0_valid |  prio);
          if (grant0) begin
            ram_en      = 1'b1;
            ram_we      = r0_wstrb;
            ram_addr    = r0_addr;
            ram_din     = r0_wdata;
            rvalid0Next = (r0_wstrb == WE_NONE);
            prioNext    = 1'b1;
          end else if (grant1) begin
            ram_en      = 1'b1;
            ram_we      = r1_wstrb;
            ram_addr    = r1_addr;
            ram_din     = r1_wdata;
            rvalid1Next = (r1_wstrb == WE_NONE);
            prioNext    = 1'b0;
          end else begin
            prioNext = prio;
          end
        end
      end

      default: begin
        stateNext = START;
        cntNext   = ADDR_ZERO;
      end
    endcase
  end

  assign r0_ready  = grant0;
  assign r1_ready  = grant1;
  assign r0_rvalid = rvalid0;
  assign r1_rvalid = rvalid1;
  // Both requesters see the RAM output; only the one with rvalid consumes it.
  assign r0_rdata  = ram_dout;
  assign r1_rdata  = ram_dout;

endmodule

// File: tb/tb_iob_tdp_ram_be_arb.sv
// Self-checking bench for iob_tdp_ram_be_arb with a behavioural
// byte-enable RAM on the port and a scoreboard of expected read returns.

module tb_iob_tdp_ram_be_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       busy;
  logic       r0_valid, r1_valid;
  logic [3:0] r0_addr, r1_addr;
  logic [1:0] r0_wstrb, r1_wstrb;
  logic [7:0] r0_wdata, r1_wdata;
  logic       r0_ready, r1_ready;
  logic       r0_rvalid, r1_rvalid;
  logic [7:0] r0_rdata, r1_rdata;
  logic       ram_en;
  logic [1:0] ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         due;
    int         who;
    logic [7:0] data;
  } expT;
  expT        expQ[$];
  logic [7:0] refMem [16];
  logic [7:0] ramMem [16];

  iob_tdp_ram_be_arb dut (
    .clk(clk), .rst(rst), .clr(clr), .busy(busy),
    .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_wstrb(r0_wstrb), .r0_wdata(r0_wdata),
    .r0_ready(r0_ready), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_wstrb(r1_wstrb), .r1_wdata(r1_wdata),
    .r1_ready(r1_ready), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Cycle counter used to time-stamp expected read returns.
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM port: read-first, 1-cycle latency, nonzero content at reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) ramMem[i] <= 8'(i * 7 + 3);
      ram_dout <= 8'h00;
    end else if (ram_en) begin
      for (int c = 0; c < 2; c++)
        if (ram_we[c]) ramMem[ram_addr][c*4 +: 4] <= ram_din[c*4 +: 4];
      ram_dout <= ramMem[ram_addr];
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Scoreboard: compare rvalid/rdata of both requesters every cycle.
  always @(negedge clk) begin : monitor
    logic       e0, e1;
    logic [7:0] ed;
    e0 = 1'b0;
    e1 = 1'b0;
    ed = 8'h00;
    if (expQ.size() > 0 && expQ[0].due == cyc) begin
      if (expQ[0].who == 0) e0 = 1'b1;
      else                  e1 = 1'b1;
      ed = expQ[0].data;
      void'(expQ.pop_front());
    end
    checkVal("r0_rvalid", {31'd0, r0_rvalid}, {31'd0, e0});
    checkVal("r1_rvalid", {31'd0, r1_rvalid}, {31'd0, e1});
    if (e0) checkVal("r0_rdata", {24'd0, r0_rdata}, {24'd0, ed});
    if (e1) checkVal("r1_rdata", {24'd0, r1_rdata}, {24'd0, ed});
  end

  task automatic checkResetState();
    checkVal("rst_busy",   {31'd0, busy},      32'd1);
    checkVal("rst_ready0", {31'd0, r0_ready},  32'd0);
    checkVal("rst_ready1", {31'd0, r1_ready},  32'd0);
    checkVal("rst_rvalid0",{31'd0, r0_rvalid}, 32'd0);
    checkVal("rst_rvalid1",{31'd0, r1_rvalid}, 32'd0);
    checkVal("rst_ram_en", {31'd0, ram_en},    32'd0);
    checkVal("rst_ram_we", {30'd0, ram_we},    32'd0);
    checkVal("rst_ram_addr",{28'd0, ram_addr}, 32'd0);
    checkVal("rst_ram_din",{24'd0, ram_din},   32'd0);
  endtask

  task automatic checkClearCycle(input int i);
    checkVal("clr_busy",  {31'd0, busy},     32'd1);
    checkVal("clr_en",    {31'd0, ram_en},   32'd1);
    checkVal("clr_we",    {30'd0, ram_we},   32'd3);
    checkVal("clr_addr",  {28'd0, ram_addr}, i);
    checkVal("clr_din",   {24'd0, ram_din},  32'd0);
    checkVal("clr_ready0",{31'd0, r0_ready}, 32'd0);
    checkVal("clr_ready1",{31'd0, r1_ready}, 32'd0);
  endtask

  // Called at a negedge just before the clear starts; both requesters
  // keep a read pending throughout to prove nothing is granted.
  task automatic clearSeq();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      clr = 1'b0;
      r0_valid = 1'b1; r0_wstrb = 2'b00;
      r1_valid = 1'b1; r1_wstrb = 2'b00;
      #1;
      checkClearCycle(i);
    end
    @(negedge clk);
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    #1;
    checkVal("serve_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 16; i++) refMem[i] = 8'h00;
  endtask

  // One SERVE cycle: drive both requesters, check the grant and port,
  // update the reference memory / scoreboard, advance to next negedge.
  task automatic step(input logic v0, input logic [3:0] a0, input logic [1:0] s0, input logic [7:0] d0,
                      input logic v1, input logic [3:0] a1, input logic [1:0] s1, input logic [7:0] d1,
                      input logic e0, input logic e1);
    logic [3:0] a;
    logic [1:0] s;
    logic [7:0] d;
    r0_valid = v0; r0_addr = a0; r0_wstrb = s0; r0_wdata = d0;
    r1_valid = v1; r1_addr = a1; r1_wstrb = s1; r1_wdata = d1;
    #1;
    checkVal("ready0", {31'd0, r0_ready}, {31'd0, e0});
    checkVal("ready1", {31'd0, r1_ready}, {31'd0, e1});
    if (e0 || e1) begin
      a = e0 ? a0 : a1;
      s = e0 ? s0 : s1;
      d = e0 ? d0 : d1;
      checkVal("grant_en",   {31'd0, ram_en},   32'd1);
      checkVal("grant_we",   {30'd0, ram_we},   {30'd0, s});
      checkVal("grant_addr", {28'd0, ram_addr}, {28'd0, a});
      if (s != 2'b00) begin
        checkVal("grant_din", {24'd0, ram_din}, {24'd0, d});
        for (int c = 0; c < 2; c++)
          if (s[c]) refMem[a][c*4 +: 4] = d[c*4 +: 4];
      end else begin
        expQ.push_back('{due: cyc + 1, who: (e0 ? 0 : 1), data: refMem[a]});
      end
    end else begin
      checkVal("idle_en", {31'd0, ram_en}, 32'd0);
      checkVal("idle_we", {30'd0, ram_we}, 32'd0);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0;
    r0_valid = 1'b0; r0_addr = 4'd0; r0_wstrb = 2'b00; r0_wdata = 8'h00;
    r1_valid = 1'b0; r1_addr = 4'd0; r1_wstrb = 2'b00; r1_wdata = 8'h00;
    for (int i = 0; i < 16; i++) refMem[i] = 8'h00;

    // Reset state and release: START then 16 clear writes.
    repeat (3) @(negedge clk);
    #1;
    checkResetState();
    rst = 1'b0;
    #1;
    checkVal("start_busy", {31'd0, busy},   32'd1);
    checkVal("start_en",   {31'd0, ram_en}, 32'd0);
    clearSeq();
    @(negedge clk);

    // Every address reads zero after the clear (requester 1 alone).
    for (int i = 0; i < 16; i++)
      step(1'b0, 4'd0, 2'b00, 8'h00, 1'b1, 4'(i), 2'b00, 8'h00, 1'b0, 1'b1);

    // Seed two words, leaving prio back at requester 0.
    step(1'b1, 4'd1, 2'b11, 8'h11, 1'b0, 4'd0, 2'b00, 8'h00, 1'b1, 1'b0);
    step(1'b0, 4'd0, 2'b00, 8'h00, 1'b1, 4'd2, 2'b11, 8'h22, 1'b0, 1'b1);

    // Contention: both read continuously, grants alternate r0, r1, ...
    for (int k = 0; k < 6; k++)
      step(1'b1, 4'd1, 2'b00, 8'h00, 1'b1, 4'd2, 2'b00, 8'h00, (k % 2 == 0), (k % 2 == 1));

    // Requester 0 alone: full write, read back, then upper-column write.
    step(1'b1, 4'd3, 2'b11, 8'hA5, 1'b0, 4'd0, 2'b00, 8'h00, 1'b1, 1'b0);
    step(1'b1, 4'd3, 2'b00, 8'h00, 1'b0, 4'd0, 2'b00, 8'h00, 1'b1, 1'b0);
    step(1'b1, 4'd3, 2'b10, 8'h3C, 1'b0, 4'd0, 2'b00, 8'h00, 1'b1, 1'b0);
    step(1'b1, 4'd3, 2'b00, 8'h00, 1'b0, 4'd0, 2'b00, 8'h00, 1'b1, 1'b0);
    step(1'b0, 4'd0, 2'b00, 8'h00, 1'b0, 4'd0, 2'b00, 8'h00, 1'b0, 1'b0);

    // clr with traffic: read in flight, then a clr cycle with no grant.
    step(1'b1, 4'd3, 2'b00, 8'h00, 1'b0, 4'd0, 2'b00, 8'h00, 1'b1, 1'b0);
    clr = 1'b1;
    r0_valid = 1'b1; r0_addr = 4'd1; r0_wstrb = 2'b00;
    r1_valid = 1'b1; r1_addr = 4'd2; r1_wstrb = 2'b00;
    #1;
    checkVal("clrcyc_ready0", {31'd0, r0_ready}, 32'd0);
    checkVal("clrcyc_ready1", {31'd0, r1_ready}, 32'd0);
    checkVal("clrcyc_en",     {31'd0, ram_en},   32'd0);
    clearSeq();
    @(negedge clk);
    for (int i = 1; i < 4; i++)
      step(1'b1, 4'(i), 2'b00, 8'h00, 1'b0, 4'd0, 2'b00, 8'h00, 1'b1, 1'b0);

    // Reset mid-clear at cnt=7: immediate reset values, full restart.
    step(1'b1, 4'd5, 2'b11, 8'h77, 1'b0, 4'd0, 2'b00, 8'h00, 1'b1, 1'b0);
    clr = 1'b1;
    r0_valid = 1'b0; r1_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      clr = 1'b0;
      #1;
      checkClearCycle(i);
    end
    rst = 1'b1;
    expQ.delete();
    #1;
    checkResetState();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkVal("restart_busy", {31'd0, busy}, 32'd1);
    clearSeq();
    @(negedge clk);

    // prio is back at requester 0; the seeded word at address 5 is gone.
    for (int k = 0; k < 4; k++)
      step(1'b1, 4'd5, 2'b00, 8'h00, 1'b1, 4'd2, 2'b00, 8'h00, (k % 2 == 0), (k % 2 == 1));
    step(1'b0, 4'd0, 2'b00, 8'h00, 1'b0, 4'd0, 2'b00, 8'h00, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checkVal("scoreboard_empty", expQ.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
